// File: rtl/bitstream_byte_serializer.sv
// bitstream_byte_serializer
// Buffers configuration words in a small FIFO and emits them one bit per
// beat on a 1-bit stream. A word tagged last marks its final bit with tlast.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no word loaded; output invalid, waiting for FIFO data
// SHIFT | a word is loaded; presenting one bit per output beat
module bitstream_byte_serializer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int LSB_FIRST  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] words_tdata,
  input  logic              words_tvalid,
  input  logic              words_tlast,
  output logic              words_tready,
  output logic              bitstream_tdata,
  output logic              bitstream_tvalid,
  output logic              bitstream_tlast,
  input  logic              bitstream_tready,
  output logic              busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ITER_W = $clog2(DATA_W);
  localparam logic [ITER_W-1:0] LAST_BIT = ITER_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [DATA_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic                in_ready_en;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic [DATA_W:0]     head;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_shifted;
  logic                word_last;
  logic [ITER_W-1:0]   bit_iter;
  logic                at_last_bit;
  logic                out_hs;

  assign fifo_empty   = (fifo_count == '0);
  assign fifo_full    = (fifo_count == FULL_CNT);
  // in_ready_en keeps tready low until the first edge after reset release
  assign words_tready = in_ready_en && !fifo_full;
  assign push         = words_tvalid && words_tready;
  assign head         = mem[rd_ptr];

  assign at_last_bit      = (bit_iter == LAST_BIT);
  assign bitstream_tvalid = (state == SHIFT);
  assign out_hs           = bitstream_tvalid && bitstream_tready;
  assign bitstream_tdata  = (state == SHIFT) &&
                            ((LSB_FIRST != 0) ? shreg[0] : shreg[DATA_W-1]);
  assign bitstream_tlast  = (state == SHIFT) && word_last && at_last_bit;
  assign busy             = !fifo_empty || (state == SHIFT);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {words_tlast, words_tdata};
  end

  // FIFO pointers, occupancy and post-reset input enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      in_ready_en <= 1'b0;
    end else begin
      in_ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Shift toward the end the bit is emitted from
  always_comb begin
    shreg_shifted = shreg;
    if (LSB_FIRST != 0) shreg_shifted = shreg >> 1;
    else                shreg_shifted = shreg << 1;
  end

  // Next-state and pop decision
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bitstream_tready && at_last_bit) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = IDLE;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shift register, last flag and bit position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg     <= '0;
      word_last <= 1'b0;
      bit_iter  <= '0;
    end else if (pop) begin
      shreg     <= head[DATA_W-1:0];
      word_last <= head[DATA_W];
      bit_iter  <= '0;
    end else if (out_hs) begin
      shreg <= shreg_shifted;
      if (!at_last_bit) bit_iter <= bit_iter + 1'b1;
    end
  end

endmodule

// File: tb/tb_bitstream_byte_serializer.sv
// Self-checking bench for bitstream_byte_serializer: LSB-first instance for
// most scenarios, a second MSB-first instance for bit-order checks.
module tb_bitstream_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] w_tdata = '0;
  logic       w_tvalid = 1'b0, w_tlast = 1'b0, w_tready;
  logic       b_tdata, b_tvalid, b_tlast, b_tready = 1'b0, busy;
  logic [7:0] m_w_tdata = '0;
  logic       m_w_tvalid = 1'b0, m_w_tlast = 1'b0, m_w_tready;
  logic       m_b_tdata, m_b_tvalid, m_b_tlast, m_b_tready = 1'b0, m_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hold_viol = 0;
  bit stalled = 0, sd = 0, sl = 0;

  bit rx_d[$], rx_l[$], mrx_d[$], mrx_l[$], exp_d[$], exp_l[$];
  int rx_c[$];

  always #5 clk = ~clk;

  bitstream_byte_serializer #(.DATA_W(8), .FIFO_DEPTH(2), .LSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .words_tdata(w_tdata), .words_tvalid(w_tvalid), .words_tlast(w_tlast),
    .words_tready(w_tready),
    .bitstream_tdata(b_tdata), .bitstream_tvalid(b_tvalid),
    .bitstream_tlast(b_tlast), .bitstream_tready(b_tready),
    .busy(busy));

  bitstream_byte_serializer #(.DATA_W(8), .FIFO_DEPTH(2), .LSB_FIRST(0)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .words_tdata(m_w_tdata), .words_tvalid(m_w_tvalid), .words_tlast(m_w_tlast),
    .words_tready(m_w_tready),
    .bitstream_tdata(m_b_tdata), .bitstream_tvalid(m_b_tvalid),
    .bitstream_tlast(m_b_tlast), .bitstream_tready(m_b_tready),
    .busy(m_busy));

  // Beat collection and valid-hold monitoring on pre-edge values
  always @(posedge clk) begin
    if (rst_n && b_tvalid && b_tready) begin
      rx_d.push_back(b_tdata);
      rx_l.push_back(b_tlast);
      rx_c.push_back(cyc);
    end
    if (rst_n && m_b_tvalid && m_b_tready) begin
      mrx_d.push_back(m_b_tdata);
      mrx_l.push_back(m_b_tlast);
    end
    if (!rst_n) stalled = 0;
    else begin
      if (stalled && (b_tvalid !== 1'b1 || b_tdata !== sd || b_tlast !== sl))
        hold_viol++;
      stalled = b_tvalid && !b_tready;
      sd = b_tdata;
      sl = b_tlast;
    end
    cyc++;
  end

  // Reference: a word becomes DATA_W beats, tlast only on the final beat of a tagged word
  function automatic void model_word(input logic [7:0] w, input bit last, input bit lsb);
    for (int i = 0; i < 8; i++) begin
      exp_d.push_back(lsb ? w[i] : w[7-i]);
      exp_l.push_back(last && (i == 7));
    end
  endfunction

  function automatic void clear_q();
    rx_d.delete(); rx_l.delete(); rx_c.delete();
    mrx_d.delete(); mrx_l.delete();
    exp_d.delete(); exp_l.delete();
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input bit l);
    w_tdata = d; w_tlast = l; w_tvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (w_tready) begin
        step();
        w_tvalid = 1'b0;
        return;
      end
      step();
    end
    w_tvalid = 1'b0;
    checks++; errors++;
    $display("FAIL push_timeout word=%02h never accepted", d);
  endtask

  task automatic wait_beats(input int n, input int bound);
    for (int i = 0; i < bound && rx_d.size() < n; i++) step();
    if (rx_d.size() < n) begin
      checks++; errors++;
      $display("FAIL beat_timeout got %0d beats want %0d", rx_d.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (w_tready !== 1'b0) begin errors++; $display("FAIL rst_w_tready got %b want 0", w_tready); end
    checks++; if (b_tvalid !== 1'b0) begin errors++; $display("FAIL rst_b_tvalid got %b want 0", b_tvalid); end
    checks++; if (b_tdata !== 1'b0) begin errors++; $display("FAIL rst_b_tdata got %b want 0", b_tdata); end
    checks++; if (b_tlast !== 1'b0) begin errors++; $display("FAIL rst_b_tlast got %b want 0", b_tlast); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    checks++; if (w_tready !== 1'b0) begin errors++; $display("FAIL rel_w_tready_early got %b want 0", w_tready); end
    step();
    checks++; if (w_tready !== 1'b1) begin errors++; $display("FAIL rel_w_tready got %b want 1", w_tready); end
  endtask

  task automatic test_single();
    clear_q();
    b_tready = 1'b1;
    model_word(8'hA5, 1'b0, 1'b1);
    w_tdata = 8'hA5; w_tlast = 1'b0; w_tvalid = 1'b1;
    checks++; if (w_tready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", w_tready); end
    step();
    w_tvalid = 1'b0;
    checks++; if (b_tvalid !== 1'b0) begin errors++; $display("FAIL single_lat1 tvalid got %b want 0", b_tvalid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    step();
    checks++; if (b_tvalid !== 1'b1) begin errors++; $display("FAIL single_lat2 tvalid got %b want 1", b_tvalid); end
    repeat (8) step();
    checks++; if (busy !== 1'b0 || b_tvalid !== 1'b0) begin errors++; $display("FAIL single_done busy=%b tvalid=%b want 0 0", busy, b_tvalid); end
    checks++; if (rx_d.size() != exp_d.size()) begin errors++; $display("FAIL single_beats got %0d want %0d", rx_d.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL single_bit%0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    b_tready = 1'b1;
    model_word(8'h3C, 1'b0, 1'b1);
    model_word(8'hC3, 1'b1, 1'b1);
    push(8'h3C, 1'b0);
    push(8'hC3, 1'b1);
    wait_beats(16, 100);
    repeat (3) step();
    checks++; if (rx_d.size() != 16) begin errors++; $display("FAIL b2b_beats got %0d want 16", rx_d.size()); end
    if (rx_c.size() >= 16) begin
      checks++;
      if (rx_c[15] - rx_c[0] != 15) begin errors++; $display("FAIL b2b_gap span got %0d want 15", rx_c[15] - rx_c[0]); end
    end
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL b2b_bit%0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w;
    int ready_seen;
    clear_q();
    hold_viol = 0;
    b_tready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      w = 8'($urandom);
      model_word(w, k == 2, 1'b1);
      push(w, k == 2);
    end
    step();
    checks++; if (w_tready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", w_tready); end
    checks++; if (b_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid got %b want 1", b_tvalid); end
    ready_seen = 0;
    w_tdata = 8'h5A; w_tlast = 1'b0; w_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (w_tready) ready_seen++;
      step();
    end
    w_tvalid = 1'b0;
    checks++; if (ready_seen != 0) begin errors++; $display("FAIL bp_stall ready cycles got %0d want 0", ready_seen); end
    b_tready = 1'b1;
    wait_beats(24, 100);
    repeat (5) step();
    checks++; if (rx_d.size() != 24) begin errors++; $display("FAIL bp_beats got %0d want 24", rx_d.size()); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold violations got %0d want 0", hold_viol); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b want 0", busy); end
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL bp_bit%0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic run_random(input string name, input logic [7:0] wq[$], input bit lq[$]);
    clear_q();
    hold_viol = 0;
    foreach (wq[k]) model_word(wq[k], lq[k], 1'b1);
    fork
      begin
        foreach (wq[k]) push(wq[k], lq[k]);
      end
      begin
        for (int i = 0; i < 2000 && rx_d.size() < exp_d.size(); i++) begin
          b_tready = 1'($urandom_range(0, 1));
          step();
        end
        b_tready = 1'b1;
      end
    join
    repeat (4) step();
    checks++; if (rx_d.size() != exp_d.size()) begin errors++; $display("FAIL %s_beats got %0d want %0d", name, rx_d.size(), exp_d.size()); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL %s_hold violations got %0d want 0", name, hold_viol); end
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL %s_bit%0d got d=%b l=%b want d=%b l=%b", name, i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    logic [7:0] wq[$];
    bit lq[$];
    wq = '{8'h01, 8'h80, 8'hFF, 8'h00};
    lq = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_random("rready", wq, lq);
  endtask

  task automatic test_random_words();
    logic [7:0] wq[$];
    bit lq[$];
    for (int k = 0; k < 8; k++) begin
      wq.push_back(8'($urandom));
      lq.push_back(1'($urandom_range(0, 1)));
    end
    run_random("rwords", wq, lq);
  endtask

  task automatic test_msb_first();
    bit accepted;
    clear_q();
    model_word(8'hA5, 1'b1, 1'b0);
    m_b_tready = 1'b1;
    m_w_tdata = 8'hA5; m_w_tlast = 1'b1; m_w_tvalid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = m_w_tready;
      step();
    end
    m_w_tvalid = 1'b0;
    for (int i = 0; i < 50 && mrx_d.size() < 8; i++) step();
    repeat (3) step();
    checks++; if (mrx_d.size() != 8) begin errors++; $display("FAIL msb_beats got %0d want 8", mrx_d.size()); end
    for (int i = 0; i < exp_d.size() && i < mrx_d.size(); i++) begin
      checks++;
      if (mrx_d[i] !== exp_d[i] || mrx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL msb_bit%0d got d=%b l=%b want d=%b l=%b", i, mrx_d[i], mrx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    b_tready = 1'b1;
    push(8'hF0, 1'b0);
    push(8'($urandom), 1'b1);
    wait_beats(3, 50);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid got %b want 0", b_tvalid); end
    checks++; if (w_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_tready got %b want 0", w_tready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    repeat (2) step();
    rst_n = 1'b1;
    clear_q();
    repeat (20) step();
    checks++; if (rx_d.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_residual beats=%0d busy=%b want 0 0", rx_d.size(), busy); end
    model_word(8'h0F, 1'b0, 1'b1);
    push(8'h0F, 1'b0);
    wait_beats(8, 50);
    repeat (3) step();
    checks++; if (rx_d.size() != 8) begin errors++; $display("FAIL mid_fresh_beats got %0d want 8", rx_d.size()); end
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== exp_d[i] || rx_l[i] !== exp_l[i]) begin
        errors++; $display("FAIL mid_fresh_bit%0d got d=%b l=%b want d=%b l=%b", i, rx_d[i], rx_l[i], exp_d[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_random_words();
    test_msb_first();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_byte_serializer.md
Name: bitstream_byte_serializer

Overview:
- Upstream feeder of the bitstream reader stage.
- Accepts configuration bytes on a byte-wide AXI-stream slave, which the chip-level wrapper drives from input pins, and buffers them in a small FIFO.
- Serialises each byte into a 1-bit AXI-stream master, LSB first by default, that drives the reader's bitstream port.
- A byte tagged tlast produces tlast on its final bit, marking the end of the configuration image.

Parameters:
- DATA_W, default 8: input word width in bits; must be >= 2.
- FIFO_DEPTH, default 2: input word buffer entries; power of two, >= 2.
- LSB_FIRST, default 1: 1 emits bit 0 first; 0 emits bit DATA_W-1 first.

Ports:
- clk  in  1: single clock; all logic on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- words  axi_stream_if.slave  tdata DATA_W, tvalid/tready/tlast 1: input byte stream.
- bitstream  axi_stream_if.master  tdata 1, tvalid/tready/tlast 1: serial output bit stream.
- busy  out  1: high while the FIFO is non-empty or a word is being shifted.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle):
  - FIFO pointers and count cleared; state forced to IDLE; shift register and bit counter cleared.
  - Outputs: words.tready=0, bitstream.tvalid=0, bitstream.tdata=0, bitstream.tlast=0, busy=0.
  - Any word in flight is discarded.
  - One cycle after rst_n deasserts, words.tready=1.
- Input handshake:
  - words.tready = !fifo_full, decoded from a registered count; no combinational path from bitstream.tready.
  - A push occurs on an edge where tvalid && tready; the FIFO stores {tlast, tdata}.
  - When the FIFO is full, input is stalled; data is never overwritten.
- FIFO:
  - Count width is $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves the count unchanged; both pointers advance.
  - With a full FIFO, a pop frees a slot, but tready rises only on the next cycle.
- State machine, states IDLE and SHIFT:
  - IDLE: bitstream.tvalid=0. If the FIFO is non-empty: pop, load the shift register and last flag, clear bit_iter, go to SHIFT.
  - SHIFT: bitstream.tvalid=1.
    - tdata = shreg[0] if LSB_FIRST, else shreg[DATA_W-1].
    - tlast = word_last && (bit_iter == DATA_W-1).
  - On each output handshake (tvalid && tready):
    - Shift by one toward the emitted end.
    - If bit_iter != DATA_W-1, increment it.
  - Handshake on bit DATA_W-1:
    - FIFO non-empty: pop, reload, bit_iter=0, stay in SHIFT. Back-to-back words have no bubble.
    - FIFO empty: go to IDLE.
  - When bitstream.tready is low, tdata, tlast and tvalid hold stable; the AXI valid-hold rule applies.
  - tvalid never depends combinationally on tready.
- Latency:
  - A word pushed into an empty block on edge N is popped on edge N+1.
  - Its first bit is valid after edge N+1, i.e. 2 cycles after the input handshake.
  - Sustained throughput is 1 bit/cycle while bitstream.tready=1.
- tlast:
  - Asserted only with the final bit of a word tagged tlast, for exactly one output beat.
  - Untagged words never produce tlast.
  - After a tlast beat the block continues with any queued words; no special state.
- busy = (fifo_count != 0) || (state == SHIFT), registered-source decode.
- Widths:
  - bit_iter is $clog2(DATA_W) bits and is compared against DATA_W-1 cast to that width.
  - All increments are truncating; no overflow is reachable.

Test Plan:
- Reset then push 8'hA5, bitstream.tready=1 → tdata sequence 1,0,1,0,0,1,0,1 (LSB first). tvalid first high 2 cycles after the handshake. tlast=0 throughout. busy falls after the 8th beat.
- Push 8'h3C then 8'hC3 (tlast=1) back-to-back, tready=1 → 16 consecutive beats with no tvalid gap. Bits 0,0,1,1,1,1,0,0,1,1,0,0,0,0,1,1. tlast only on beat 16.
- Push 3 words with bitstream.tready=0 and FIFO_DEPTH=2 → words.tready=0 after the FIFO fills. Output holds tdata/tvalid stable. Raising tready drains all 24 bits in order with no data loss.
- Toggle bitstream.tready randomly (50%) across 4 words 8'h01, 8'h80, 8'hFF, 8'h00 → the received bit stream equals the LSB-first concatenation. tdata never changes while tvalid && !tready.
- LSB_FIRST=0: push 8'hA5 with tlast=1 → bits 1,0,1,0,0,1,0,1 (MSB first) with tlast on beat 8.
- Assert rst_n low mid-word (after 3 beats of 8'hF0, 1 more queued) → tvalid, tready and busy drop asynchronously. After release there are no residual beats, and a fresh push of 8'h0F emits 1,1,1,1,0,0,0,0.
